// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector stream loader: the loader state
// encoding, the index-width helper and the per-load element count.
package mv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_MAT = 2'd1,
        LOAD_VEC = 2'd2,
        FIRE     = 2'd3
    } state_t;

    // Width of a row/column index for an N-element dimension (at least 1 bit)
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Number of stream elements consumed by one complete load
    function automatic int elem_count(input int n);
        return n * n + n;
    endfunction

endpackage

// File: rtl/mv_stream_loader_idx_cnt.sv
// Row/column wrap counter shared by the matrix and vector load phases.
// The column advances on each enable and wraps after N-1, carrying into
// the row. Limits are compared against N-1 so N need not be a power of two.
module mv_idx_cnt
    import mv_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         col_wrap,
    output logic         last
);

    localparam logic [W-1:0] MAX_IDX = W'(N - 1);

    assign col_wrap = (col == MAX_IDX);
    assign last     = col_wrap && (row == MAX_IDX);

    // Column counts every enable; its wrap carries into the row, which itself wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                row <= (row == MAX_IDX) ? '0 : row + W'(1);
            end else begin
                col <= col + W'(1);
            end
        end
    end

endmodule

// File: rtl/mv_stream_loader.sv
// Stream loader for the matrix-vector wrapper. Consumes a valid/ready stream
// of N*N matrix elements (row-major) followed by N vector elements, writes
// them into the row memories and the vector memory, then pulses start.
// Optional framing check on s_last: define MV_STREAM_LOADER_LAST_CHK_EN.
module mv_stream_loader
    import mv_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_req,
    input  logic [DW-1:0]           s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [DW-1:0]           rom_mat_data    [0:N-1],
    output logic [idx_width(N)-1:0] rom_mat_wr_addr [0:N-1],
    output logic [0:N-1]            rom_mat_we,
    output logic [DW-1:0]           rom_vec_data,
    output logic [idx_width(N)-1:0] rom_vec_wr_addr,
    output logic                    rom_vec_we,
    output logic                    start,
    output logic                    busy,
    output logic                    frame_err
);

    localparam int W = idx_width(N);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   row;
    logic [W-1:0]   col;
    logic           col_wrap;
    logic           last_elem;
    logic           xfer;
    logic           chk_err;
    logic           cnt_clr;
    logic           cnt_en;
    logic           mat_wr;
    logic           vec_wr;
    logic           start_q;

    assign s_ready = (state_q == LOAD_MAT) || (state_q == LOAD_VEC);
    assign xfer    = s_valid && s_ready;
    assign start   = start_q;
    // Busy also covers the start cycle so it drops only after the pulse
    assign busy    = (state_q != IDLE) || start_q;

    mv_idx_cnt #(
        .N (N),
        .W (W)
    ) u_idx_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .row      (row),
        .col      (col),
        .col_wrap (col_wrap),
        .last     (last_elem)
    );

`ifdef MV_STREAM_LOADER_LAST_CHK_EN
    logic final_elem;
    logic frame_err_q;

    // The only element allowed to carry s_last is the last vector element
    assign final_elem = (state_q == LOAD_VEC) && col_wrap;
    assign chk_err    = xfer && (s_last != final_elem);
    assign frame_err  = frame_err_q;

    // Sticky framing error, cleared by reset or by the next accepted load request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
        end else if ((state_q == IDLE) && load_req) begin
            frame_err_q <= 1'b0;
        end else if (chk_err) begin
            frame_err_q <= 1'b1;
        end
    end
`else
    // Without the framing check s_last has no role and the flag stays low
    assign chk_err   = 1'b0;
    assign frame_err = 1'b0 & s_last;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-transfer control; a framing error drops the transfer and aborts
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        mat_wr  = 1'b0;
        vec_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    cnt_clr = 1'b1;
                    state_d = LOAD_MAT;
                end
            end
            LOAD_MAT: begin
                if (xfer) begin
                    if (chk_err) begin
                        state_d = IDLE;
                    end else begin
                        mat_wr = 1'b1;
                        if (last_elem) begin
                            cnt_clr = 1'b1;
                            state_d = LOAD_VEC;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
            end
            LOAD_VEC: begin
                if (xfer) begin
                    if (chk_err) begin
                        state_d = IDLE;
                    end else begin
                        vec_wr = 1'b1;
                        cnt_en = 1'b1;
                        if (col_wrap) begin
                            state_d = FIRE;
                        end
                    end
                end
            end
            FIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Matrix write port: enable pulses for one cycle, data and address hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_mat_we <= '0;
            for (int r = 0; r < N; r++) begin
                rom_mat_data[r]    <= '0;
                rom_mat_wr_addr[r] <= '0;
            end
        end else begin
            rom_mat_we <= '0;
            if (mat_wr) begin
                rom_mat_we[row]      <= 1'b1;
                rom_mat_wr_addr[row] <= col;
                rom_mat_data[row]    <= s_data;
            end
        end
    end

    // Vector write port: enable pulses for one cycle, data and address hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_vec_we      <= 1'b0;
            rom_vec_data    <= '0;
            rom_vec_wr_addr <= '0;
        end else begin
            rom_vec_we <= 1'b0;
            if (vec_wr) begin
                rom_vec_we      <= 1'b1;
                rom_vec_wr_addr <= col;
                rom_vec_data    <= s_data;
            end
        end
    end

    // Start is loaded during FIRE so it appears the cycle after the last vector write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= (state_q == FIRE);
        end
    end

endmodule

// File: tb/tb_mv_stream_loader.sv
// Self-checking bench for mv_stream_loader (N=2, DW=8). A monitor logs every
// write, start pulse and busy fall with its cycle number; each test task
// compares the log against expectations derived from the stream order.
module tb_mv_stream_loader;

    localparam int N  = 2;
    localparam int DW = 8;

    typedef struct {
        int row;
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          load_req;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [DW-1:0] rom_mat_data    [0:N-1];
    logic [0:0]    rom_mat_wr_addr [0:N-1];
    logic [0:N-1]  rom_mat_we;
    logic [DW-1:0] rom_vec_data;
    logic [0:0]    rom_vec_wr_addr;
    logic          rom_vec_we;
    logic          start;
    logic          busy;
    logic          frame_err;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            xfer_count = 0;
    logic          prev_busy = 1'b0;
    wr_t           mat_log[$];
    wr_t           vec_log[$];
    int            start_log[$];
    int            busy_fall_log[$];
    int            xfer_q[$];
    logic [DW-1:0] stream_q[$];

    mv_stream_loader #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_req        (load_req),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_last          (s_last),
        .rom_mat_data    (rom_mat_data),
        .rom_mat_wr_addr (rom_mat_wr_addr),
        .rom_mat_we      (rom_mat_we),
        .rom_vec_data    (rom_vec_data),
        .rom_vec_wr_addr (rom_vec_wr_addr),
        .rom_vec_we      (rom_vec_we),
        .start           (start),
        .busy            (busy),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample settled outputs just after each falling edge
    always begin
        wr_t w;
        @(negedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (rom_mat_we[r] === 1'b1) begin
                w.row  = r;
                w.addr = int'(rom_mat_wr_addr[r]);
                w.data = int'(rom_mat_data[r]);
                w.cyc  = cyc;
                mat_log.push_back(w);
            end
        end
        if (rom_vec_we === 1'b1) begin
            w.row  = -1;
            w.addr = int'(rom_vec_wr_addr);
            w.data = int'(rom_vec_data);
            w.cyc  = cyc;
            vec_log.push_back(w);
        end
        if (start === 1'b1) start_log.push_back(cyc);
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_log.push_back(cyc);
        prev_busy = busy;
        if (s_valid === 1'b1 && s_ready === 1'b1) xfer_count++;
    end

    task automatic clear_logs();
        @(posedge clk);
        mat_log.delete();
        vec_log.delete();
        start_log.delete();
        busy_fall_log.delete();
        xfer_count = 0;
        @(negedge clk);
    endtask

    task automatic fill_stream(input bit rand_data);
        stream_q.delete();
        for (int i = 0; i < N * N + N; i++)
            stream_q.push_back(rand_data ? DW'($urandom_range(0, 255)) : DW'(i + 1));
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Drive 'count' stream elements starting at a falling edge.
    // stall_mode: 0 none, 1 two idle cycles between elements, 2 random 0..3.
    task automatic drive_stream(input int stall_mode, input int last_pos,
                                input int count, input int req_pos);
        xfer_q.delete();
        for (int i = 0; i < count; i++) begin
            int waitc;
            int gap;
            s_data  = stream_q[i];
            s_last  = (i == last_pos);
            s_valid = 1'b1;
            if (i == req_pos) load_req = 1'b1;
            waitc = 0;
            while (s_ready !== 1'b1 && waitc < 20) begin
                @(negedge clk);
                load_req = 1'b0;
                waitc++;
            end
            if (s_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL ready_timeout element %0d: s_ready=%b, required 1 within 20 cycles", i, s_ready);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            xfer_q.push_back(cyc);
            @(negedge clk);
            load_req = 1'b0;
            gap = (stall_mode == 1) ? 2 : (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            if (gap > 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = DW'($urandom_range(0, 255));
                repeat (gap) @(negedge clk);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            s_data = DW'($urandom_range(0, 255));
            @(negedge clk);
        end
        #1;
        checks++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: start=%b busy=%b, required 0 0", start, busy);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: s_ready=%b, required 0", s_ready);
        end
        checks++;
        if (rom_mat_we !== 2'b00 || rom_vec_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_we: mat_we=%b vec_we=%b, required 00 0", rom_mat_we, rom_vec_we);
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (rom_mat_data[r] !== 8'h00 || rom_mat_wr_addr[r] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mat_row%0d: data=%h addr=%b, required 00 0", r, rom_mat_data[r], rom_mat_wr_addr[r]);
            end
        end
        checks++;
        if (rom_vec_data !== 8'h00 || rom_vec_wr_addr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_vec: data=%h addr=%b, required 00 0", rom_vec_data, rom_vec_wr_addr);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_err: frame_err=%b, required 0", frame_err);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || xfer_count != 0) begin
            errors++;
            $display("[TB] FAIL idle_ignores_stream: s_ready=%b busy=%b xfers=%0d, required 0 0 0", s_ready, busy, xfer_count);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_stream_load(input int stall_mode, input bit rand_data, input string tag);
        fill_stream(rand_data);
        clear_logs();
        pulse_load();
        drive_stream(stall_mode, N * N + N - 1, N * N + N, -1);
        repeat (6) @(negedge clk);
        checks++;
        if (mat_log.size() != N * N) begin
            errors++;
            $display("[TB] FAIL %s mat_count: got %0d writes, required %0d", tag, mat_log.size(), N * N);
        end
        for (int k = 0; k < N * N && k < mat_log.size() && k < xfer_q.size(); k++) begin
            checks++;
            if (mat_log[k].row != k / N || mat_log[k].addr != k % N ||
                mat_log[k].data != int'(stream_q[k]) || mat_log[k].cyc != xfer_q[k] + 1) begin
                errors++;
                $display("[TB] FAIL %s mat_write%0d: row=%0d addr=%0d data=%0d cyc=%0d, required %0d %0d %0d %0d",
                         tag, k, mat_log[k].row, mat_log[k].addr, mat_log[k].data, mat_log[k].cyc,
                         k / N, k % N, stream_q[k], xfer_q[k] + 1);
            end
        end
        checks++;
        if (vec_log.size() != N) begin
            errors++;
            $display("[TB] FAIL %s vec_count: got %0d writes, required %0d", tag, vec_log.size(), N);
        end
        for (int k = 0; k < N && k < vec_log.size() && N * N + k < xfer_q.size(); k++) begin
            checks++;
            if (vec_log[k].addr != k || vec_log[k].data != int'(stream_q[N * N + k]) ||
                vec_log[k].cyc != xfer_q[N * N + k] + 1) begin
                errors++;
                $display("[TB] FAIL %s vec_write%0d: addr=%0d data=%0d cyc=%0d, required %0d %0d %0d",
                         tag, k, vec_log[k].addr, vec_log[k].data, vec_log[k].cyc,
                         k, stream_q[N * N + k], xfer_q[N * N + k] + 1);
            end
        end
        checks++;
        if (start_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL %s start_count: got %0d pulses, required 1", tag, start_log.size());
        end else if (xfer_q.size() == N * N + N) begin
            checks++;
            if (start_log[0] != xfer_q[N * N + N - 1] + 2) begin
                errors++;
                $display("[TB] FAIL %s start_latency: start at cycle %0d, required %0d",
                         tag, start_log[0], xfer_q[N * N + N - 1] + 2);
            end
            checks++;
            if (busy_fall_log.size() != 1 || busy_fall_log[0] != start_log[0] + 1) begin
                errors++;
                $display("[TB] FAIL %s busy_fall: falls=%0d first=%0d, required 1 at cycle %0d",
                         tag, busy_fall_log.size(),
                         (busy_fall_log.size() > 0) ? busy_fall_log[0] : -1, start_log[0] + 1);
            end
        end
        checks++;
        if (xfer_count != N * N + N) begin
            errors++;
            $display("[TB] FAIL %s xfer_count: got %0d, required %0d", tag, xfer_count, N * N + N);
        end
    endtask

    task automatic test_reset_abort();
        fill_stream(1'b1);
        clear_logs();
        pulse_load();
        drive_stream(0, -1, 3, -1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: busy=%b s_ready=%b start=%b, required 0 0 0", busy, s_ready, start);
        end
        checks++;
        if (rom_mat_we !== 2'b00 || rom_vec_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_we: mat_we=%b vec_we=%b, required 00 0", rom_mat_we, rom_vec_we);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (start_log.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_start: starts=%0d busy=%b, required 0 0", start_log.size(), busy);
        end
        test_stream_load(0, 1'b1, "after_abort");
    endtask

    task automatic test_load_req_ignored();
        fill_stream(1'b1);
        clear_logs();
        pulse_load();
        drive_stream(0, N * N + N - 1, N * N + N, 3);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (xfer_count != N * N + N) begin
            errors++;
            $display("[TB] FAIL reload_xfers: got %0d, required %0d", xfer_count, N * N + N);
        end
        checks++;
        if (start_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL reload_start: got %0d pulses, required 1", start_log.size());
        end
        checks++;
        if (mat_log.size() != N * N || vec_log.size() != N) begin
            errors++;
            $display("[TB] FAIL reload_writes: mat=%0d vec=%0d, required %0d %0d", mat_log.size(), vec_log.size(), N * N, N);
        end
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 4; t++) test_stream_load(2, 1'b1, "random");
    endtask

    task automatic test_last_check();
        fill_stream(1'b0);
        clear_logs();
        pulse_load();
`ifdef MV_STREAM_LOADER_LAST_CHK_EN
        drive_stream(0, 3, 4, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL last_err_set: frame_err=%b, required 1", frame_err);
        end
        checks++;
        if (mat_log.size() != 3) begin
            errors++;
            $display("[TB] FAIL last_err_write: got %0d writes, required 3", mat_log.size());
        end
        checks++;
        if (start_log.size() != 0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_err_idle: starts=%0d busy=%b s_ready=%b, required 0 0 0",
                     start_log.size(), busy, s_ready);
        end
        pulse_load();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_err_clear: frame_err=%b, required 0", frame_err);
        end
        drive_stream(0, N * N + N - 1, N * N + N, -1);
        repeat (4) @(negedge clk);
        checks++;
        if (start_log.size() != 1 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_err_recover: starts=%0d frame_err=%b, required 1 0", start_log.size(), frame_err);
        end
`else
        drive_stream(0, 3, N * N + N, -1);
        repeat (4) @(negedge clk);
        checks++;
        if (start_log.size() != 1 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_ignored: starts=%0d frame_err=%b, required 1 0", start_log.size(), frame_err);
        end
        checks++;
        if (mat_log.size() != N * N || vec_log.size() != N) begin
            errors++;
            $display("[TB] FAIL last_ignored_writes: mat=%0d vec=%0d, required %0d %0d", mat_log.size(), vec_log.size(), N * N, N);
        end
`endif
    endtask

    initial begin
        rst      = 1'b0;
        load_req = 1'b0;
        s_valid  = 1'b1;
        s_last   = 1'b0;
        s_data   = '0;
        $display("[TB] mv_stream_loader bench start");
        test_reset();
        test_stream_load(0, 1'b0, "basic");
        test_stream_load(1, 1'b0, "stall");
        test_reset_abort();
        test_load_req_ignored();
        test_random_loads();
        test_last_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
